// File: rtl/debounce_scan_ctrl.sv
// Small show-ahead FIFO; head visible while not empty, no write-through bypass.
// A push while full is ignored unless a pop happens in the same cycle.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// Round-robin debouncer: one channel sampled per PRESCALE-clk slot; a level flips after
// STABLE_CYCLES differing samples, and each flip is queued as an event drained by evt_valid/evt_ready.
module debounce_scan_ctrl #(
  parameter int NUM_CH        = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int PRESCALE      = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NUM_CH-1:0]         noisy_in,
  output logic [NUM_CH-1:0]         clean_out,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(NUM_CH)-1:0] evt_ch,
  output logic                      evt_rise,
  output logic                      overflow,
  input  logic                      clr_overflow
);
  localparam int CW = $clog2(NUM_CH);
  localparam int NW = $clog2(STABLE_CYCLES + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [PW-1:0]     pre_cnt;
  logic [CW-1:0]     ptr;
  logic [NW-1:0]     cnt [NUM_CH];

  logic          strobe;
  logic          samp;
  logic          differ;
  logic          flip;
  logic          pop;
  logic          empty;
  logic          full;
  logic [CW:0]   head_dat;

  assign strobe = enable && (pre_cnt == PW'(PRESCALE - 1));
  assign samp   = sync2[ptr];
  assign differ = (samp != clean_out[ptr]);
  assign flip   = strobe && differ && (cnt[ptr] == NW'(STABLE_CYCLES - 1));
  assign pop    = evt_valid && evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= noisy_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt   <= '0;
      ptr       <= '0;
      clean_out <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else if (enable) begin
      pre_cnt <= strobe ? '0 : pre_cnt + PW'(1);
      if (strobe) begin
        ptr <= (ptr == CW'(NUM_CH - 1)) ? '0 : ptr + CW'(1);
        if (!differ) begin
          cnt[ptr] <= '0;
        end else if (flip) begin
          cnt[ptr]       <= '0;
          clean_out[ptr] <= samp;
        end else begin
          cnt[ptr] <= cnt[ptr] + NW'(1);
        end
      end
    end
  end

  fifo #(.W(CW + 1), .DEPTH(FIFO_DEPTH)) u_evt_q (
    .clk      (clk),
    .rst      (rst),
    .push     (flip),
    .push_dat ({ptr, samp}),
    .pop      (pop),
    .pop_dat  (head_dat),
    .empty    (empty),
    .full     (full)
  );

  assign evt_valid = !empty;
  assign evt_ch    = empty ? '0 : head_dat[CW:1];
  assign evt_rise  = empty ? 1'b0 : head_dat[0];

  // A dropped event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (flip && full && !pop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_debounce_scan_ctrl.sv
// Directed bench for debounce_scan_ctrl at default parameters (slot 16, revisit 64 clks).
module tb_debounce_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] noisy_in;
  logic [3:0] clean_out;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_rise;
  logic       overflow;
  logic       clr_overflow;

  int checks   = 0;
  int failures = 0;

  debounce_scan_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .noisy_in     (noisy_in),
    .clean_out    (clean_out),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_ch       (evt_ch),
    .evt_rise     (evt_rise),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // Waits for clean_out[ch]==val; t returns the number of edges taken, or 0 on timeout.
  task automatic wait_clean(input int ch, input logic val, input int bound, output int t);
    t = 0;
    for (int n = 1; n <= bound; n++) begin
      step(1);
      if (clean_out[ch] === val) begin
        t = n;
        break;
      end
    end
    checks++;
    if (t == 0) begin
      failures++;
      $display("FAIL wait_clean ch%0d: clean_out=%b, wanted bit=%b within %0d clks", ch, clean_out, val, bound);
    end
  endtask

  task automatic test_reset();
    bit seen = 0;
    rst = 1'b1; enable = 1'b1; noisy_in = 4'b0000; evt_ready = 1'b1; clr_overflow = 1'b0;
    #1;
    checks++;
    if ({clean_out, evt_valid, evt_ch, evt_rise, overflow} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, wanted 0", {clean_out, evt_valid, evt_ch, evt_rise, overflow});
    end
    step(1);
    rst = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      step(1);
      if (evt_valid === 1'b1 || clean_out !== 4'b0) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL idle_quiet: activity seen=%0d clean_out=%b, wanted none", seen, clean_out);
    end
  endtask

  task automatic test_rise();
    int t_flip = 0;
    int nevt   = 0;
    logic [1:0] ch = 2'd0;
    logic rise = 1'b0;
    noisy_in[2] = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      step(1);
      if (evt_valid === 1'b1) begin
        nevt++; ch = evt_ch; rise = evt_rise;
      end
      if (clean_out[2] === 1'b1 && t_flip == 0) t_flip = n;
    end
    checks++;
    if (t_flip < 192 || t_flip > 323) begin
      failures++;
      $display("FAIL rise_latency: %0d clks, wanted 192..323", t_flip);
    end
    checks++;
    if (nevt != 1 || ch !== 2'd2 || rise !== 1'b1) begin
      failures++;
      $display("FAIL rise_event: count=%0d ch=%0d rise=%b, wanted 1/2/1", nevt, ch, rise);
    end
    checks++;
    if (clean_out !== 4'b0100) begin
      failures++;
      $display("FAIL rise_clean: %b, wanted 0100", clean_out);
    end
  endtask

  task automatic test_glitch();
    bit seen = 0;
    int t;
    noisy_in[1] = 1'b1;
    for (int n = 0; n < 100; n++) begin
      step(1);
      if (evt_valid === 1'b1) seen = 1;
    end
    noisy_in[1] = 1'b0;
    for (int n = 0; n < 300; n++) begin
      step(1);
      if (evt_valid === 1'b1 || clean_out !== 4'b0100) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL glitch_ignored: activity=%0d clean_out=%b, wanted none/0100", seen, clean_out);
    end
    // A leftover count would shorten the next debounce below three revisits.
    noisy_in[1] = 1'b1;
    wait_clean(1, 1'b1, 400, t);
    checks++;
    if (t < 192) begin
      failures++;
      $display("FAIL glitch_cnt_cleared: reflip after %0d clks, wanted >=192", t);
    end
  endtask

  task automatic test_overflow();
    int t;
    do_reset();
    evt_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      noisy_in[c] = 1'b1;
      wait_clean(c, 1'b1, 400, t);
    end
    noisy_in[0] = 1'b0;
    wait_clean(0, 1'b0, 400, t);
    checks++;
    if (overflow !== 1'b1 || evt_valid !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: overflow=%b evt_valid=%b, wanted 1/1", overflow, evt_valid);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (evt_valid !== 1'b1 || evt_ch !== 2'(i) || evt_rise !== 1'b1) begin
        failures++;
        $display("FAIL pop_order[%0d]: valid=%b ch=%0d rise=%b, wanted 1/%0d/1", i, evt_valid, evt_ch, evt_rise, i);
      end
      step(1);
    end
    checks++;
    if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL drained: evt_valid=%b overflow=%b, wanted 0/1", evt_valid, overflow);
    end
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL overflow_clear: %b, wanted 0", overflow);
    end
  endtask

  task automatic test_enable();
    int t;
    noisy_in = 4'b0000;
    do_reset();
    enable = 1'b0;
    noisy_in[3] = 1'b1;
    step(1000);
    checks++;
    if (clean_out !== 4'b0000 || evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL enable_hold: clean_out=%b evt_valid=%b, wanted 0000/0", clean_out, evt_valid);
    end
    enable = 1'b1;
    wait_clean(3, 1'b1, 323, t);
  endtask

  task automatic test_midscan_reset();
    rst = 1'b1;
    noisy_in = 4'b0001;
    step(1);
    rst = 1'b0;
    // ch0 is sampled on edges 16, 80, 144, 208 after release.
    step(180);
    checks++;
    if (clean_out !== 4'b0000) begin
      failures++;
      $display("FAIL pending_before_reset: %b, wanted 0000", clean_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({clean_out, evt_valid, evt_ch, evt_rise, overflow} !== 9'b0) begin
      failures++;
      $display("FAIL midscan_reset_outputs: got %b, wanted 0", {clean_out, evt_valid, evt_ch, evt_rise, overflow});
    end
    step(1);
    rst = 1'b0;
    step(200);
    checks++;
    if (clean_out !== 4'b0000) begin
      failures++;
      $display("FAIL progress_discarded: at edge 200 %b, wanted 0000", clean_out);
    end
    step(10);
    checks++;
    if (clean_out !== 4'b0001) begin
      failures++;
      $display("FAIL full_rescan: at edge 210 %b, wanted 0001", clean_out);
    end
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_overflow();
    test_enable();
    test_midscan_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
